// File: rtl/heap_bounds_table.sv
// Table of live heap block base addresses with oldest-slot replacement and a
// 2-stage bounds check. Optional saturating statistics counters under HBT_STATS_EN.
module heap_bounds_table #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       alloc_valid_i,
  input  logic [ADDR_W-1:0]          alloc_base_i,
  input  logic                       free_valid_i,
  input  logic [ADDR_W-1:0]          free_base_i,
  input  logic                       chk_valid_i,
  input  logic [ADDR_W-1:0]          chk_base_i,
  input  logic [ADDR_W-1:0]          chk_addr_i,
  output logic                       chk_valid_o,
  output logic                       chk_overflow_o,
  output logic                       evict_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic [CNT_W-1:0]           ovf_cnt_o,
  output logic [CNT_W-1:0]           evict_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CW    = IDX_W + 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] base_q [DEPTH];
  logic [ADDR_W-1:0] base_d [DEPTH];
  logic [IDX_W-1:0]  cursor_q, cursor_d;
  logic [CW-1:0]     count_q, count_d;
  logic              evict_q, evict_d;

  logic [DEPTH-1:0]  free_match;
  logic              alloc_hit;
  logic              alloc_do;
  logic [CW-1:0]     n_free;

  always_comb begin
    free_match = '0;
    alloc_hit  = 1'b0;
    n_free     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_match[i] = free_valid_i && valid_q[i] && (base_q[i] == free_base_i);
      if (valid_q[i] && (base_q[i] == alloc_base_i)) alloc_hit = 1'b1;
      n_free = n_free + {{(CW-1){1'b0}}, free_match[i]};
    end
  end

  // Free is applied first so a slot freed this cycle is seen as invalid by the insert.
  always_comb begin
    alloc_do = alloc_valid_i && (alloc_base_i != '0) && !alloc_hit &&
               !(free_valid_i && (free_base_i == alloc_base_i));
    valid_d  = valid_q & ~free_match;
    base_d   = base_q;
    cursor_d = cursor_q;
    evict_d  = 1'b0;
    if (alloc_do) begin
      evict_d          = valid_d[cursor_q];
      valid_d[cursor_q] = 1'b1;
      base_d[cursor_q]  = alloc_base_i;
      cursor_d         = cursor_q + IDX_W'(1);
    end
    count_d = count_q - n_free + {{(CW-1){1'b0}}, (alloc_do && !evict_d)};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      cursor_q <= '0;
      count_q  <= '0;
      evict_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) base_q[i] <= '0;
    end else begin
      valid_q  <= valid_d;
      cursor_q <= cursor_d;
      count_q  <= count_d;
      evict_q  <= evict_d;
      for (int i = 0; i < DEPTH; i++) base_q[i] <= base_d[i];
    end
  end

  logic              s1_found_d;
  logic [ADDR_W-1:0] s1_next_d;
  logic              s1_valid_q, s1_found_q;
  logic [ADDR_W-1:0] s1_next_q, s1_addr_q;
  logic              chk_valid_q, chk_ovf_q;

  // Smallest live base strictly above the accessed block's base.
  always_comb begin
    s1_found_d = 1'b0;
    s1_next_d  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (base_q[i] > chk_base_i) &&
          (!s1_found_d || (base_q[i] < s1_next_d))) begin
        s1_found_d = 1'b1;
        s1_next_d  = base_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_found_q  <= 1'b0;
      s1_next_q   <= '0;
      s1_addr_q   <= '0;
      chk_valid_q <= 1'b0;
      chk_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= chk_valid_i;
      s1_found_q  <= s1_found_d;
      s1_next_q   <= s1_next_d;
      s1_addr_q   <= chk_addr_i;
      chk_valid_q <= s1_valid_q;
      chk_ovf_q   <= s1_valid_q && s1_found_q && (s1_addr_q >= s1_next_q);
    end
  end

  assign chk_valid_o    = chk_valid_q;
  assign chk_overflow_o = chk_ovf_q;
  assign evict_o        = evict_q;
  assign count_o        = count_q;
  assign full_o         = (count_q == CW'(DEPTH));

`ifdef HBT_STATS_EN
  logic [CNT_W-1:0] ovf_cnt_q, evict_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_cnt_q   <= '0;
      evict_cnt_q <= '0;
    end else begin
      if (chk_valid_q && chk_ovf_q && (ovf_cnt_q != '1)) ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
      if (evict_q && (evict_cnt_q != '1)) evict_cnt_q <= evict_cnt_q + CNT_W'(1);
    end
  end

  assign ovf_cnt_o   = ovf_cnt_q;
  assign evict_cnt_o = evict_cnt_q;
`else
  assign ovf_cnt_o   = '0;
  assign evict_cnt_o = '0;
`endif

endmodule

// File: doc/heap_bounds_table.md
Name: heap_bounds_table

Overview:
- Parametrised successor to the base-address circular buffer in the heap-overflow detection path.
- Stores up to DEPTH allocated block base addresses, each with a valid bit. Supports allocate, free and pipelined bounds-check requests.
- A check flags an access that reaches or passes the next higher live base address.
- Sits beside the LSU. Allocations and frees come from the custom-instruction decode; checks come from each load/store.

Parameters:
ADDR_W, 32, address width in bits
DEPTH, 32, number of entries; power of two, >=2
CNT_W, 16, width of statistics counters (used only with HBT_STATS_EN)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
alloc_valid_i  in  1  allocate request, one cycle per request
alloc_base_i  in  ADDR_W  base address to insert
free_valid_i  in  1  free request
free_base_i  in  ADDR_W  base address to invalidate
chk_valid_i  in  1  bounds-check request
chk_base_i  in  ADDR_W  base of the block being accessed
chk_addr_i  in  ADDR_W  accessed address
chk_valid_o  out  1  check result valid
chk_overflow_o  out  1  access overflows into the next live block
evict_o  out  1  pulse: an allocation overwrote a valid entry
count_o  out  $clog2(DEPTH)+1  number of valid entries
full_o  out  1  count_o == DEPTH
ovf_cnt_o  out  CNT_W  overflow counter (HBT_STATS_EN)
evict_cnt_o  out  CNT_W  eviction counter (HBT_STATS_EN)

Behaviour:
- Reset (async, rst_ni low):
  - All entries invalid, base fields 0, cursor 0.
  - Pipeline valids 0.
  - All outputs 0.
- Allocate:
  - Base 0 is reserved: alloc_base_i == 0 is ignored.
  - If alloc_base_i matches any valid entry, the request is a no-op: no cursor move, no evict.
  - Otherwise write {valid=1, base} to slot[cursor]. Cursor increments modulo DEPTH (wraps DEPTH-1 -> 0).
  - If slot[cursor] was valid before the write, pulse evict_o for one cycle, registered.
  - Oldest-slot replacement applies even if earlier slots were freed. Holes are not reused out of order.
- Free:
  - Clear the valid bit of every entry whose base equals free_base_i.
  - A miss is a no-op. The cursor is unaffected.
- Simultaneous allocate and free:
  - Same base: free wins, and the allocate is dropped.
  - Different bases: both apply. If the freed entry is slot[cursor], the allocate overwrites it with no evict (the freed slot counts as invalid for the evict decision).
- Count:
  - count_o is registered and updated the same cycle as the table: +1 for a successful insert into an invalid slot, -1 per freed entry.
  - Eviction leaves the count unchanged.
- Check pipeline, latency 2, one request per cycle, no back-pressure:
  - S1 (capture cycle registered): among valid entries with base > chk_base_i, select the minimum as next_base, plus found flag. Register next_base, found and chk_addr_i.
  - S2: chk_overflow_o = found && (addr >= next_base). chk_valid_o = S1 valid.
  - Both outputs are registered.
  - A check request at cycle N yields chk_valid_o high at cycle N+2.
  - Comparisons are unsigned, full ADDR_W.
- Ordering:
  - A check samples the table state present at the start of its S1 cycle.
  - Allocate or free requests in that same cycle are not visible to it.
- Reset mid-operation: in-flight checks are discarded, with no chk_valid_o after reset release.

Optional Feature:
- Macro: HBT_STATS_EN.
- Defined:
  - ovf_cnt_o increments on each chk_valid_o && chk_overflow_o.
  - evict_cnt_o increments on each evict_o.
  - Both saturate at 2^CNT_W-1 and reset to 0.
- Undefined:
  - Counters are not instantiated.
  - ovf_cnt_o and evict_cnt_o are tied to 0; the ports remain present.

Test Plan:
- Reset, then allocate 0x1000, 0x2000. Check base=0x1000 addr=0x1FFC -> chk_valid_o at +2 cycles, overflow=0. Addr=0x2000 -> overflow=1. count_o=2.
- Allocate 0x1000 twice, then allocate 0 -> count_o=1, cursor advanced once, no evict_o.
- DEPTH=4: allocate 0x100, 0x200, 0x300, 0x400, then 0x500 -> evict_o pulse, full_o=1, count_o=4. Slot 0 = 0x500; 0x100 no longer matches on free.
- Allocate 0x1000, 0x2000, 0x3000; free 0x2000. Check base=0x1000 addr=0x2800 -> overflow=0; addr=0x3000 -> overflow=1.
- Same cycle: allocate 0x4000 and free 0x4000 (0x4000 previously valid) -> entry invalid, count decrements by 1. Back-to-back checks in consecutive cycles -> results in consecutive cycles.
- HBT_STATS_EN defined, CNT_W=2: 5 overflowing checks -> ovf_cnt_o saturates at 3. Macro undefined -> ovf_cnt_o stays 0.
